// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Types shared by the instruction register and its readback stage, the reader
// FSM state encoding, and the reference arithmetic for the stored-result check.
//   REG_ADDR_W    : address width of the register file (32 entries)
//   operand_t     : signed 32-bit operand
//   result_t      : signed 64-bit result (wide enough for a full 32x32 product)
//   opcode_t      : ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
//   instruction_t : {opc, op_a, op_b, res}
//   reader_state_t: IDLE, FETCH, OUT
//   calc_expected : recomputes the result an entry should hold
// -----------------------------------------------------------------------------
package instr_register_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic signed [31:0]      operand_t;
  typedef logic signed [63:0]      result_t;
  typedef logic [REG_ADDR_W-1:0]   address_t;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE, FETCH, OUT
  } reader_state_t;

  // Operands are sign-extended to the result width before any arithmetic;
  // division by zero is defined to yield 0 rather than X.
  function automatic result_t calc_expected(opcode_t opc, operand_t a, operand_t b);
    result_t ea;
    result_t eb;
    result_t r;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (opc)
      ZERO:    r = '0;
      PASSA:   r = ea;
      PASSB:   r = eb;
      ADD:     r = ea + eb;
      SUB:     r = ea - eb;
      MULT:    r = ea * eb;
      DIV:     r = (eb == '0) ? '0 : ea / eb;
      MOD:     r = (eb == '0) ? '0 : ea % eb;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_expected_calc.sv
// -----------------------------------------------------------------------------
// instr_expected_calc
// Purely combinational: opcode + operands -> result the entry should contain.
// Ports:
//   opc      in  opcode_t  : operation
//   op_a     in  operand_t : first operand
//   op_b     in  operand_t : second operand
//   expected out result_t  : recomputed result
// -----------------------------------------------------------------------------
module instr_expected_calc
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  expected
);

  always_comb begin
    expected = calc_expected(opc, op_a, op_b);
  end

endmodule

// File: rtl/instr_reader.sv
// -----------------------------------------------------------------------------
// instr_reader
// Walks a range of instruction-register entries, captures each word and
// presents it on a valid/ready stream, flagging entries whose stored result
// disagrees with the recomputed one.
// Build option: define INSTR_READER_CHECK_EN to build the result checker;
// without it out_mismatch and error_count are constant 0.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : begin a readback (sampled in IDLE only)
//   start_addr, count  : first entry, number of entries (0..32)
//   read_pointer       : registered address to the instruction register
//   instruction_word   : combinational read data for read_pointer
//   out_valid/out_ready: output stream handshake
//   out_word, out_addr : captured entry and the address it came from
//   out_mismatch       : stored result differs from recomputed result
//   busy, done         : not-IDLE indicator, one-cycle completion pulse
//   error_count        : saturating mismatch count since reset
// -----------------------------------------------------------------------------
module instr_reader
  import instr_register_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
)
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  address_t           start_addr,
  input  logic [ADDR_W:0]    count,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_word,
  output address_t           out_addr,
  output logic               out_mismatch,
  output logic               busy,
  output logic               done,
  output logic [7:0]         error_count
);

  reader_state_t      state_q, state_d;
  address_t           read_pointer_q, read_pointer_d;
  logic [ADDR_W:0]    remaining_q, remaining_d;
  logic               out_valid_q, out_valid_d;
  instruction_t       out_word_q, out_word_d;
  address_t           out_addr_q, out_addr_d;
  logic               done_q, done_d;
  logic               handshake;

  assign handshake = out_valid_q && out_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      read_pointer_q <= '0;
      remaining_q    <= '0;
      out_valid_q    <= 1'b0;
      out_word_q     <= '0;
      out_addr_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_pointer_q <= read_pointer_d;
      remaining_q    <= remaining_d;
      out_valid_q    <= out_valid_d;
      out_word_q     <= out_word_d;
      out_addr_q     <= out_addr_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (count != '0)) state_d = FETCH;
      FETCH:   state_d = OUT;
      OUT:     if (handshake) state_d = (remaining_q != '0) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register updates per state; remaining counts words not yet fetched, so a
  // zero at handshake time means the word being accepted is the last one.
  always_comb begin
    read_pointer_d = read_pointer_q;
    remaining_d    = remaining_q;
    out_valid_d    = out_valid_q;
    out_word_d     = out_word_q;
    out_addr_d     = out_addr_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            read_pointer_d = start_addr;
            remaining_d    = count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        out_word_d  = instruction_word;
        out_addr_d  = read_pointer_q;
        remaining_d = remaining_q - (ADDR_W+1)'(1);
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (remaining_q != '0) begin
            read_pointer_d = read_pointer_q + address_t'(1);  // wraps 31 -> 0
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy         = (state_q != IDLE);
    done         = done_q;
    out_valid    = out_valid_q;
    out_word     = out_word_q;
    out_addr     = out_addr_q;
    read_pointer = read_pointer_q;
  end

`ifdef INSTR_READER_CHECK_EN
  result_t    expected;
  logic       mismatch_q, mismatch_d;
  logic [7:0] error_count_q, error_count_d;

  instr_expected_calc u_expected_calc (
    .opc      (instruction_word.opc),
    .op_a     (instruction_word.op_a),
    .op_b     (instruction_word.op_b),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_q    <= 1'b0;
      error_count_q <= '0;
    end else begin
      mismatch_q    <= mismatch_d;
      error_count_q <= error_count_d;
    end
  end

  // The compare is taken alongside the word capture; the counter moves only
  // when a flagged word is actually accepted downstream.
  always_comb begin
    mismatch_d    = mismatch_q;
    error_count_d = error_count_q;
    if (state_q == FETCH) mismatch_d = (expected != instruction_word.res);
    if (handshake && mismatch_q && (error_count_q != 8'hFF))
      error_count_d = error_count_q + 8'd1;
  end

  assign out_mismatch = mismatch_q;
  assign error_count  = error_count_q;
`else
  assign out_mismatch = 1'b0;
  assign error_count  = 8'd0;
`endif

endmodule

// File: tb/tb_instr_reader.sv
module tb_instr_reader;
  import instr_register_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready;
  instruction_t out_word;
  address_t     out_addr;
  logic         out_mismatch;
  logic         busy;
  logic         done;
  logic [7:0]   error_count;

  instruction_t mem [32];
  int n_chk = 0;
  int n_err = 0;
  int ref_err = 0;

  instr_reader #(.ADDR_W(5)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_word         (out_word),
    .out_addr         (out_addr),
    .out_mismatch     (out_mismatch),
    .busy             (busy),
    .done             (done),
    .error_count      (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction register model: combinational read of the addressed entry.
  always_comb instruction_word = mem[read_pointer];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic in plain 64-bit integers.
  function automatic longint ref_res(input instruction_t w);
    longint a;
    longint b;
    longint r;
    a = longint'(w.op_a);
    b = longint'(w.op_b);
    case (w.opc)
      PASSA:   r = a;
      PASSB:   r = b;
      ADD:     r = a + b;
      SUB:     r = a - b;
      MULT:    r = a * b;
      DIV:     r = (b == 0) ? 0 : a / b;
      MOD:     r = (b == 0) ? 0 : a % b;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t w;
    w.opc  = o;
    w.op_a = a;
    w.op_b = b;
    w.res  = '0;
    w.res  = ref_res(w);
    return w;
  endfunction

  function automatic logic exp_mm(input instruction_t w);
`ifdef INSTR_READER_CHECK_EN
    return (ref_res(w) != longint'(w.res));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_errcnt();
`ifdef INSTR_READER_CHECK_EN
    return ref_err;
`else
    return 0;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_rp"},    read_pointer, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_word"},  out_word, 0);
    chk({tag, "_addr"},  out_addr, 0);
    chk({tag, "_mm"},    out_mismatch, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ecnt"},  error_count, 0);
  endtask

  // One readback; optional stall of 'stall' cycles on the first word.
  task automatic do_read(input address_t sa, input int cnt, input int stall);
    instruction_t w;
    address_t     a;
    logic         mm;
    out_ready  = (stall == 0);
    start_addr = sa;
    count      = cnt[5:0];
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (cnt == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_valid", out_valid, 0);
      @(negedge clk);
      chk("zero_done_drop", done, 0);
      chk("zero_valid2", out_valid, 0);
      return;
    end
    chk("busy", busy, 1);
    chk("fetch_valid_low", out_valid, 0);
    for (int i = 0; i < cnt; i++) begin
      a  = sa + address_t'(i);
      w  = mem[a];
      mm = exp_mm(w);
      if (i > 0) begin
        @(negedge clk);
        chk("valid_low_between", out_valid, 0);
      end
      @(negedge clk);
      chk("valid", out_valid, 1);
      chk("word", out_word, w);
      chk("addr", out_addr, a);
      chk("mismatch", out_mismatch, mm);
      chk("rp", read_pointer, a);
      if (i == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_word", out_word, w);
          chk("stall_addr", out_addr, a);
          chk("stall_rp", read_pointer, a);
        end
        out_ready = 1'b1;
      end
      if (mm && ref_err < 255) ref_err++;
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
    chk("errcnt", error_count, exp_errcnt());
    @(negedge clk);
    chk("done_drop", done, 0);
  endtask

  initial begin
    instruction_t w;
    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = mk(opcode_t'($urandom_range(0, 7)), int'($urandom), int'($urandom));
    mem[0] = mk(ADD, 5, 3);
    mem[1] = mk(SUB, 5, 7);
    mem[2] = mk(MULT, -4, 6);
    mem[3] = mk(PASSB, 11, 9);
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed results 8, -2, -24, 9
    chk("res0", mem[0].res, 64'd8);
    chk("res1", mem[1].res, -64'sd2);
    chk("res2", mem[2].res, -64'sd24);
    chk("res3", mem[3].res, 64'd9);
    do_read(5'd0, 4, 0);
    chk("errcnt_clean", error_count, 0);

    // Wrap-around and empty request
    do_read(5'd30, 4, 0);
    do_read(5'd7, 0, 0);

    // Back-pressure on the first word
    do_read(5'd1, 3, 5);

    // Corrupted stored result, and divide by zero
    w = mk(ADD, 2, 7);
    w.res = 64'd10;
    mem[5] = w;
    mem[6] = mk(DIV, 10, 0);
    chk("div0_res", mem[6].res, 0);
    do_read(5'd5, 2, 0);

    // Random contents, some corrupted, full 32-entry sweep from a random start
    for (int i = 0; i < 32; i++) begin
      w = mk(opcode_t'($urandom_range(0, 7)), int'($urandom), int'($urandom_range(0, 20)) - 10);
      if ($urandom_range(0, 3) == 0) w.res = w.res ^ 64'(1 << $urandom_range(0, 63));
      mem[i] = w;
    end
    do_read(address_t'($urandom_range(0, 31)), 32, 0);
    do_read(address_t'($urandom_range(0, 31)), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));

    // Reset while a word is waiting in OUT
    out_ready  = 1'b0;
    start_addr = 5'd2;
    count      = 6'd3;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    ref_err = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_rst");
    do_read(5'd0, 4, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_reader.md
# instr_reader

Readback stage placed directly downstream of the instruction register. On a start command it walks a range of register entries by driving `read_pointer`, captures each `instruction_word`, and presents it on a valid/ready output stream. It also recomputes the expected result from opcode and operands and flags any entry whose stored result disagrees. It serves as the DUT-side readout and self-check path for the lab bench.

## Interface
- `ADDR_W`, default 5: width of `address_t`; register depth is 2**ADDR_W = 32.
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a readback; sampled only in IDLE.
- `start_addr` in `address_t`: first entry to read.
- `count` in ADDR_W+1: number of entries to read, 0..32.
- `read_pointer` out `address_t`: address driven to the instruction register; registered.
- `instruction_word` in `instruction_t`: combinational read data from the register.
- `out_valid` out 1: `out_word` and `out_mismatch` are valid.
- `out_ready` in 1: consumer accepts on a cycle where `out_valid && out_ready`.
- `out_word` out `instruction_t`: captured entry.
- `out_addr` out `address_t`: address `out_word` was read from.
- `out_mismatch` out 1: stored result differs from the recomputed result.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a readback completes.
- `error_count` out 8: saturating count of mismatches since reset.

## Operation
- States: IDLE, FETCH, OUT.
- IDLE, with `start` high and `count` != 0:
  - `read_pointer` <= `start_addr`.
  - `remaining` <= `count`.
  - Go to FETCH.
- IDLE, with `start` high and `count` == 0: pulse `done` next cycle, stay in IDLE, issue no reads.
- FETCH (one cycle):
  - `instruction_word` is stable for the current `read_pointer`.
  - At the edge, latch it into `out_word`, latch `read_pointer` into `out_addr`, and latch the compare into `out_mismatch`.
  - Decrement `remaining`, set `out_valid`, go to OUT.
- OUT: hold all `out_*` stable while `out_valid && !out_ready`. On handshake:
  - Clear `out_valid`.
  - If `remaining` != 0: `read_pointer` <= `read_pointer` + 1, wrapping 31 -> 0, then go to FETCH.
  - Otherwise go to IDLE and pulse `done`.
- `start` outside IDLE is ignored; there is no queuing.
- Expected result, with operands sign-extended to the result width:
  - ZERO: 0. PASSA: a. PASSB: b. ADD: a+b. SUB: a-b. MULT: a*b.
  - DIV: a/b. MOD: a%b.
  - DIV or MOD with b == 0: expected 0.
- `error_count` increments on each accepted word with `out_mismatch` = 1 and saturates at 255.

## Timing
- Reset values: state IDLE; `read_pointer` 0; `out_valid` 0; `out_word` all zeros with `opc` ZERO; `out_addr` 0; `out_mismatch` 0; `busy` 0; `done` 0; `error_count` 0; `remaining` 0.
- Latency: `start` sampled at edge N gives `out_valid` high after edge N+1.
- Throughput: one word per 2 cycles when `out_ready` is held high.
- `out_valid` never drops without a handshake.
- `done` is high exactly one cycle, coincident with the return to IDLE.
- `busy` deasserts on the same edge that `done` rises.
- Reset asserted mid-readback: immediate return to reset values; the partial transfer is discarded.
- `count` = 32 with any `start_addr` reads every entry exactly once, wrapping through 0.

## Configuration
- `INSTR_READER_CHECK_EN`:
  - Defined: the expected-result datapath is built; `out_mismatch` and `error_count` behave as above.
  - Undefined: no arithmetic is instantiated; `out_mismatch` is tied to 0 and `error_count` to 0; the stream behaviour is unchanged.

## Structure
- Shared package `instr_register_pkg` holds `operand_t`, `opcode_t`, `address_t`, `instruction_t` and `result_t`.
- Add to the package: a `reader_state_t` enum (IDLE, FETCH, OUT) and a `calc_expected` function, so the bench scoreboard uses the same arithmetic rules.
- One sub-module: `instr_expected_calc`, combinational, computing opcode + operands -> expected result. It is instantiated only under `INSTR_READER_CHECK_EN`.

## Test plan
- Load entries 0..3 with ADD 5+3, SUB 5-7, MULT -4*6, PASSB b=9. Then `start` with `start_addr`=0, `count`=4, `out_ready`=1 -> 4 words at `out_addr` 0..3 with results 8, -2, -24, 9. `out_mismatch` stays 0, `done` pulses once, `error_count`=0.
- `start_addr`=30, `count`=4 -> `out_addr` sequence 30, 31, 0, 1. Then `count`=0 -> `done` one cycle later, `out_valid` never asserts.
- Hold `out_ready`=0 for 5 cycles on the first word -> `out_word` and `out_addr` stay stable and `read_pointer` does not advance. Release `out_ready` -> transfer resumes.
- Build with `+define+FORCE_LOAD_ERROR`, load ADD a=2 b=7, read back -> `out_mismatch`=1 and `error_count`=1. Same test without `INSTR_READER_CHECK_EN` -> `out_mismatch`=0.
- Load DIV a=10 b=0, read back -> expected 0, `out_mismatch`=0. Assert `reset_n`=0 while in OUT -> all outputs at reset values immediately, and a following `start` runs normally.
